// File: rtl/t_ff.sv
// Bank of WIDTH independent toggle flip-flops sharing one clock and reset.
// Each q bit inverts on a rising clk edge when its t bit is high.
module t_ff #(
   parameter int unsigned           WIDTH       = 1,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_next;

   // XOR with t gives per-bit toggle/hold with no interaction between bits
   assign w_q_next = r_q ^ t;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_q <= RESET_VALUE;
      end else begin
         r_q <= w_q_next;
      end
   end

   assign q = r_q;

endmodule

// File: tb/tb_t_ff.sv
// Self-checking bench for t_ff: a 1-bit default instance and a 4-bit instance
// with a non-zero reset value, checked against a toggle-count parity model.
module tb_t_ff;

   localparam logic [3:0] RV4 = 4'b1010;

   logic       clk;
   logic       rstn;
   logic       t1;
   logic [3:0] t4;
   logic       q1;
   logic [3:0] q4;

   int n_tests = 0;
   int n_fail  = 0;

   // model: each bit equals its reset value XOR the parity of toggles seen since reset
   int c1;
   int c4 [4];

   t_ff u_dut1 (
      .clk  (clk),
      .rstn (rstn),
      .t    (t1),
      .q    (q1)
   );

   t_ff #(
      .WIDTH       (4),
      .RESET_VALUE (RV4)
   ) u_dut4 (
      .clk  (clk),
      .rstn (rstn),
      .t    (t4),
      .q    (q4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic exp1();
      return logic'(c1 % 2);
   endfunction

   function automatic logic [3:0] exp4();
      logic [3:0] par;
      for (int i = 0; i < 4; i++) par[i] = ((c4[i] % 2) == 1);
      return RV4 ^ par;
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      c1 = 0;
      for (int i = 0; i < 4; i++) c4[i] = 0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_q1"}, {3'b000, q1}, {3'b000, exp1()});
      check({tag, "_q4"}, q4, exp4());
   endtask

   // called at a falling edge: drive t, take one rising edge, check 1 ns later
   task automatic edge_step(input logic a, input logic [3:0] b, input string tag);
      logic rst_ok;
      t1 = a;
      t4 = b;
      rst_ok = rstn;
      @(posedge clk);
      #1;
      if (rst_ok) begin
         c1 += int'(a);
         for (int i = 0; i < 4; i++) c4[i] += int'(b[i]);
      end
      check_model(tag);
      @(negedge clk);
   endtask

   // called at a falling edge: assert reset between edges and check without a clock
   task automatic async_reset(input string tag);
      #1;
      rstn = 1'b0;
      clear_model();
      #1;
      check({tag, "_async_q1"}, {3'b000, q1}, 4'b0000);
      check({tag, "_async_q4"}, q4, RV4);
      edge_step(1'b1, 4'b1111, {tag, "_held"});
      #2;
      rstn = 1'b1;
   endtask

   initial begin
      logic [3:0] b;
      logic       a;
      rstn = 1'b1;
      t1   = 1'b0;
      t4   = 4'b0000;
      clear_model();
      #1;
      rstn = 1'b0;
      #1;
      check("reset_q1", {3'b000, q1}, 4'b0000);
      check("reset_q4", q4, RV4);
      @(negedge clk);

      // reset hold with t toggling across edges
      for (int i = 0; i < 3; i++) edge_step(i[0], {4{i[0]}}, "rst_hold");
      check("rst_hold_q1_lit", {3'b000, q1}, 4'b0000);

      // release mid-low-phase, then continuous toggle: 1,0,1,0
      #2;
      rstn = 1'b1;
      edge_step(1'b1, 4'b0000, "cont1");
      check("cont1_lit", {3'b000, q1}, 4'b0001);
      edge_step(1'b1, 4'b0000, "cont2");
      check("cont2_lit", {3'b000, q1}, 4'b0000);
      edge_step(1'b1, 4'b0000, "cont3");
      edge_step(1'b1, 4'b0000, "cont4");
      check("cont4_lit", {3'b000, q1}, 4'b0000);

      // hold from q=1, then toggle once
      edge_step(1'b1, 4'b0000, "to_one");
      for (int i = 0; i < 3; i++) edge_step(1'b0, 4'b0000, "hold");
      check("hold_lit", {3'b000, q1}, 4'b0001);
      edge_step(1'b1, 4'b0000, "hold_then_toggle");
      check("hold_then_toggle_lit", {3'b000, q1}, 4'b0000);

      // async reset with q=1 and t=1
      edge_step(1'b1, 4'b0000, "pre_async");
      t1 = 1'b1;
      async_reset("mid_run");

      // single-cycle pulse then hold for 3 edges
      edge_step(1'b1, 4'b0000, "pulse");
      for (int i = 0; i < 3; i++) edge_step(1'b0, 4'b0000, "pulse_hold");
      check("pulse_hold_lit", {3'b000, q1}, 4'b0001);

      // 4-bit bank from its reset value
      async_reset("w4");
      check("w4_reset_lit", q4, 4'b1010);
      edge_step(1'b0, 4'b0011, "w4_t0011");
      check("w4_t0011_lit", q4, 4'b1001);
      edge_step(1'b0, 4'b0000, "w4_t0000");
      check("w4_t0000_lit", q4, 4'b1001);

      // randomized toggles with occasional mid-run reset
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            async_reset("rand_rst");
         end else begin
            a = 1'($urandom);
            b = 4'($urandom);
            edge_step(a, b, "rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/t_ff.md
# t_ff

Toggle flip-flop: on each rising clock edge the stored bit inverts when the toggle input is high and holds when it is low. It is a leaf sequential primitive for divide-by-two clock-enable chains, ripple-style counters and parity/phase trackers. A WIDTH parameter lets one instance hold a bank of independent toggle bits that share one clock and reset.

## Interface

Parameters:
- WIDTH, default 1, number of independent toggle bits. Must be ≥ 1.
- RESET_VALUE, default all zeros (WIDTH bits), value loaded into q while reset is asserted.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  reset. Asynchronous and active-low: asserting it (0) forces q to RESET_VALUE immediately, without waiting for a clock edge.
- t  input  WIDTH  toggle request. Bit i high at a rising clk edge inverts q[i].
- q  output  WIDTH  registered state. Driven directly from flops, with no combinational path from t.

## Operation

- Reset has priority over everything else.
  - While rstn = 0, q = RESET_VALUE regardless of clk and t.
  - Assertion takes effect asynchronously.
  - Default reset value of q is 0.
- With rstn = 1, at every rising edge of clk, for each bit i:
  - t[i] = 1: q[i] ← ~q[i].
  - t[i] = 0: q[i] ← q[i] (hold).
- Bits are fully independent. No carry or interaction between bits.
- With t held at 1 continuously, q[i] is a square wave at half the clk frequency, 50% duty.
- With t held at 0, q is static.
- q changes only on a rising clk edge or on reset assertion. Glitches on t between edges have no effect.
- No enable, set or load port. Any such feature is built outside this block.

## Timing

- Latency: one clock. t sampled at edge N determines q immediately after edge N.
- Reset assertion: q reaches RESET_VALUE asynchronously, no clock needed.
- Reset deassertion: the first edge that can toggle q is the first rising clk edge strictly after rstn rises.
  - rstn must meet recovery/removal timing against clk.
  - If rstn rises coincident with a clk edge, that edge is not guaranteed to toggle. Benches must not depend on it.
- Reset asserted mid-operation: q returns to RESET_VALUE at once and the toggle history is discarded.
- t must meet setup/hold around the rising clk edge.
- Unknown t: q becomes unknown after the edge. Reset recovers q to a known value.

## Test plan

- Reset hold: rstn = 0 for 3 cycles with t toggling 0/1 → q = 0 throughout, including across clk edges.
- Continuous toggle: release rstn mid-low-phase, then t = 1 for 4 edges → q goes 1, 0, 1, 0 after successive edges.
- Hold: from q = 1, set t = 0 for 3 edges → q stays 1. Then t = 1 for one edge → q = 0.
- Asynchronous reset mid-run: q = 1 and t = 1; pull rstn low between clock edges → q = 0 immediately, before the next edge. Keep rstn low across an edge → q stays 0.
- Single-cycle pulse: t = 1 for exactly one edge, then 0 → q changes once, then holds for the following 3 edges.
- WIDTH = 4, RESET_VALUE = 4'b1010: after reset q = 1010. Apply t = 0011 for one edge → q = 1001. Apply t = 0000 → q holds at 1001.
